// File: rtl/rx_block_sync_descrambler.sv
// 64b/66b receive block aligner and self-synchronous descrambler (x^58 + x^39 + 1).
// Hunts for header alignment with gearbox slips and forwards descrambled blocks while locked.
module rx_block_sync_descrambler #(
  parameter int DATA_WIDTH = 64,
  parameter int LOCK_CNT   = 64,
  parameter int WINDOW_CNT = 1024,
  parameter int ERR_MAX    = 16,
  parameter int SLIP_WAIT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH+1:0] data_in,
  input  logic                  data_valid,
  output logic                  slip,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            sync_out,
  output logic                  valid_out,
  output logic                  locked
);

  localparam int SCR_LEN = 58;
  localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW_CNT + 1);
  localparam int ERR_W   = $clog2(ERR_MAX + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);

  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CNT - 1);
  localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_MAX - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP_WAIT,
    ST_LOCKED
  } state_t;

  state_t                  state_q, state_d;
  logic [GOOD_W-1:0]       good_cnt_q, good_cnt_d;
  logic [WIN_W-1:0]        win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [SCR_LEN-1:0]      scr_q;
  logic                    slip_q, slip_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [1:0]              sync_q;

  logic [1:0]              hdr;
  logic                    hdr_ok;
  logic [DATA_WIDTH-1:0]   descr;
  logic [DATA_WIDTH+SCR_LEN-1:0] ext;

  assign hdr    = data_in[DATA_WIDTH+1:DATA_WIDTH];
  assign hdr_ok = hdr[1] ^ hdr[0];

  // Received stream, newest bit at index 0: payload bit p saw its taps 39 and 58 bits earlier,
  // which land at ext[p+39] and ext[p+58] whether they came from this block or from scr_q.
  assign ext = {scr_q, data_in[DATA_WIDTH-1:0]};

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_descr
    assign descr[gi] = ext[gi] ^ ext[gi + 39] ^ ext[gi + 58];
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    win_cnt_d  = win_cnt_q;
    err_cnt_d  = err_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip_d     = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        if (data_valid) begin
          if (!hdr_ok) begin
            slip_d     = 1'b1;
            good_cnt_d = '0;
            wait_cnt_d = '0;
            state_d    = ST_SLIP_WAIT;
          end else if (good_cnt_q == GOOD_LAST) begin
            good_cnt_d = '0;
            win_cnt_d  = '0;
            err_cnt_d  = '0;
            state_d    = ST_LOCKED;
          end else begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
          end
        end
      end

      ST_SLIP_WAIT: begin
        // Runs on every clock so the gearbox gets a fixed settling time.
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          good_cnt_d = '0;
          state_d    = ST_SEARCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ST_LOCKED: begin
        if (data_valid) begin
          if (!hdr_ok && (err_cnt_q == ERR_LAST)) begin
            slip_d     = 1'b1;
            win_cnt_d  = '0;
            err_cnt_d  = '0;
            good_cnt_d = '0;
            wait_cnt_d = '0;
            state_d    = ST_SLIP_WAIT;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            err_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, ~hdr_ok};
          end
        end
      end

      default: begin
        state_d = ST_SEARCH;
      end
    endcase

    valid_d = data_valid && (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      good_cnt_q <= '0;
      win_cnt_q  <= '0;
      err_cnt_q  <= '0;
      wait_cnt_q <= '0;
      scr_q      <= '1;
      slip_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      win_cnt_q  <= win_cnt_d;
      err_cnt_q  <= err_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_q     <= slip_d;
      valid_q    <= valid_d;
      // The descrambler keeps tracking the line even while not locked.
      if (data_valid) begin
        scr_q <= data_in[SCR_LEN-1:0];
      end
      if (valid_d) begin
        data_q <= descr;
        sync_q <= hdr;
      end
    end
  end

  assign slip      = slip_q;
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign sync_out  = sync_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: doc/rx_block_sync_descrambler.md
Name: rx_block_sync_descrambler

Overview:
Receive-side counterpart of the 64b/66b TX scrambler path. It sits between the RX gearbox and the RX decoder and does two jobs:
- Acquires and maintains 66-bit block alignment by checking sync headers and issuing slip requests to the gearbox.
- Descrambles the 64-bit payload with the self-synchronous polynomial x^58 + x^39 + 1.

Descrambled blocks are forwarded with their header only while block lock is held.

Parameters:
DATA_WIDTH, 64, payload width per block; only 64 is supported.
LOCK_CNT, 64, consecutive valid headers required to declare lock.
WINDOW_CNT, 1024, headers per error-monitoring window while locked.
ERR_MAX, 16, invalid headers within one window that cause loss of lock.
SLIP_WAIT, 32, clock cycles ignored after a slip pulse while the gearbox realigns.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
data_in  input  66  raw block from gearbox; [65:64] sync header, [63:0] scrambled payload; bit [63] is the first payload bit on the wire.
data_valid  input  1  data_in carries a new block this cycle.
slip  output  1  one-cycle pulse requesting the gearbox shift alignment by one bit.
data_out  output  64  descrambled payload, same bit ordering as data_in[63:0].
sync_out  output  2  sync header of the block on data_out.
valid_out  output  1  data_out/sync_out valid this cycle.
locked  output  1  block lock status.

Behaviour:
Reset (rst high at a clock edge):
- slip=0, valid_out=0, locked=0, data_out=0, sync_out=0.
- All counters cleared; FSM enters SEARCH.
- Descrambler state register (58 bits) set to all ones.
- rst mid-operation aborts any state immediately, including SLIP_WAIT.

Header validity:
- Valid iff header is 2'b01 or 2'b10.
- 2'b00 and 2'b11 are invalid.

Descrambler:
- Combinational over the 64 payload bits in wire order, i = 0..63, where bit i = data_in[63-i].
- out_i = in_i ^ s[38] ^ s[57], then s = {s[56:0], in_i}.
- The state shifts in received (scrambled) bits, not output bits.
- The state register updates on every cycle with data_valid=1, in every FSM state including SEARCH and SLIP_WAIT. It self-synchronises after 58 received bits.

Output timing:
- Registered, latency 1 cycle from data_valid.
- valid_out = data_valid & locked_next, where locked_next is the lock status after evaluating the current header.
- data_out/sync_out hold their previous value when valid_out=0.

FSM states: SEARCH, SLIP_WAIT, LOCKED. Only cycles with data_valid=1 evaluate a header.

SEARCH:
- Valid header: increment good_cnt.
- When good_cnt reaches LOCK_CNT (the 64th consecutive valid header): go to LOCKED; locked rises in the same cycle as valid_out for that block.
- Invalid header: assert slip for one cycle, clear good_cnt, go to SLIP_WAIT.

SLIP_WAIT:
- Wait counter runs on every clock regardless of data_valid.
- Headers are ignored and no slip is issued.
- After SLIP_WAIT cycles, return to SEARCH with good_cnt=0.

LOCKED:
- Every header increments win_cnt; an invalid header also increments err_cnt.
- If err_cnt reaches ERR_MAX before win_cnt reaches WINDOW_CNT:
  - locked=0 from that block onward; that block is not output.
  - Pulse slip, clear counters, go to SLIP_WAIT.
- When win_cnt reaches WINDOW_CNT without loss: clear both counters and stay LOCKED.
- If the ERR_MAX-th error falls on the final header of a window, loss of lock takes priority.

Other rules:
- Invalid headers while LOCKED (below threshold) are still output with valid_out=1; the decoder flags them.
- slip is never asserted on consecutive cycles.
- Counter widths cover parameter values without wrap; counters saturate never (they are cleared at their terminal event).

Test Plan:
- Lock acquisition: feed 64 blocks with header 2'b01 and data_valid=1 after reset -> locked rises with block 64, valid_out first high for block 64 (one cycle after its input), no slip.
- Search slip: 10 good headers, then header 2'b11 -> slip high exactly one cycle, slip not re-asserted for the next 32 cycles even with 2'b00 headers; after return to SEARCH, 64 good headers lock.
- Descramble round-trip: drive the TX scrambler model (all-ones seed) with incrementing 64-bit payloads and headers 2'b10 -> after lock, data_out equals the original payloads and sync_out=2'b10 on every block.
- Loss of lock: once locked, inject 15 invalid headers within 1024 -> locked stays 1. Continue into a new window with 16 invalid headers in its first 100 -> locked falls on the 16th error, slip pulses once, valid_out=0 from that block.
- Window reset: 15 errors in window 1, then 15 errors in window 2 -> locked never drops.
- Reset mid-operation: assert rst during SLIP_WAIT and again while LOCKED -> next cycle locked=0, slip=0, valid_out=0; lock reacquired after 64 good headers.
